clic_arb: RTL and testbench

CLIC_ARB -- requirements
Module: cr_clic_arb

---
 rtl/clic_arb.sv | 211 +++++++++++++++++++++
 tb/tb_clic_arb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/clic_arb.sv
// ---------------------------------------------------------------------------
// clic_arb -- scanning priority arbiter for a CLIC-style interrupt controller
//
// Each round walks the sources in groups of GRP_NUM, one group per cycle
// (SCAN). It keeps a running best: the qualifying source with the highest
// ctl, with the lower index winning ties. After the last group, one UPDATE
// cycle copies that result into the outputs. The outputs then hold for the
// whole next round. A round is INT_NUM/GRP_NUM + 1 cycles long.
//
// Optional feature (macro CLIC_ARB_THRESH_EN):
//   When the macro is defined, the int_thresh port exists. A source then
//   qualifies only if its ctl is strictly greater than int_thresh.
//   When the macro is undefined, the port is absent and no threshold applies.
//
// Ports
//   clic_clk        in   sole clock, rising edge
//   clic_rst        in   asynchronous active-high reset
//   int_pending     in   [INT_NUM]            per-source pending
//   int_enable      in   [INT_NUM]            per-source enable
//   int_ctl         in   [INT_NUM*CTL_WIDTH]  packed level/priority fields
//   int_thresh      in   [CTL_WIDTH]          threshold (CLIC_ARB_THRESH_EN only)
//   arb_clear       in   abort scan, zero outputs, return to IDLE
//   arb_sel_onehot  out  [INT_NUM]  one-hot winner (zero when no winner)
//   arb_id          out  [ID_WIDTH] encoded winner index
//   arb_ctl         out  [CTL_WIDTH] winner ctl
//   arb_vld         out  winner valid
//   arb_busy        out  high exactly in SCAN
//   dbg_state_o     out  [2] FSM state (0 IDLE, 1 SCAN, 2 UPDATE)
//
// Handshake: there is none. The outputs are registered level signals. They
// change only on an UPDATE edge, on an arb_clear edge, or on reset.
// ---------------------------------------------------------------------------
module clic_arb #(
  parameter int INT_NUM   = 64,
  parameter int CTL_WIDTH = 8,
  parameter int GRP_NUM   = 8,
  parameter int ID_WIDTH  = 6
) (
  input  logic                         clic_clk,
  input  logic                         clic_rst,
  input  logic [INT_NUM-1:0]           int_pending,
  input  logic [INT_NUM-1:0]           int_enable,
  input  logic [INT_NUM*CTL_WIDTH-1:0] int_ctl,
`ifdef CLIC_ARB_THRESH_EN
  input  logic [CTL_WIDTH-1:0]         int_thresh,
`endif
  input  logic                         arb_clear,
  output logic [INT_NUM-1:0]           arb_sel_onehot,
  output logic [ID_WIDTH-1:0]          arb_id,
  output logic [CTL_WIDTH-1:0]         arb_ctl,
  output logic                         arb_vld,
  output logic                         arb_busy,
  output logic [1:0]                   dbg_state_o
);

  localparam int NGRP = INT_NUM / GRP_NUM;
  localparam int GCW  = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [GCW-1:0] LAST_GRP = GCW'(NGRP - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [GCW-1:0]       grp_cnt_q, grp_cnt_d;
  logic                 best_vld_q, best_vld_d;
  logic [ID_WIDTH-1:0]  best_id_q, best_id_d;
  logic [CTL_WIDTH-1:0] best_ctl_q, best_ctl_d;
  logic [INT_NUM-1:0]   sel_q, sel_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;
  logic [CTL_WIDTH-1:0] ctl_q, ctl_d;
  logic                 vld_q, vld_d;

  // Unpack the ctl bus so that a source can be selected by a run-time index.
  logic [CTL_WIDTH-1:0] ctl_arr [INT_NUM];
  for (genvar gi = 0; gi < INT_NUM; gi++) begin : g_unpack
    assign ctl_arr[gi] = int_ctl[gi*CTL_WIDTH +: CTL_WIDTH];
  end

  // Fold the current group into the running best.
  // Sources are visited in ascending index order. A source replaces the best
  // only on a strictly greater ctl, so on a tie the lower index keeps the
  // slot. This holds inside a group and across groups.
  logic                 scan_vld;
  logic [ID_WIDTH-1:0]  scan_id;
  logic [CTL_WIDTH-1:0] scan_ctl;
  logic [ID_WIDTH-1:0]  src;
  logic                 qual;

  always_comb begin
    scan_vld = best_vld_q;
    scan_id  = best_id_q;
    scan_ctl = best_ctl_q;
    src      = '0;
    qual     = 1'b0;
    for (int j = 0; j < GRP_NUM; j++) begin
      src  = ID_WIDTH'(int'(grp_cnt_q) * GRP_NUM + j);
      qual = int_pending[src] & int_enable[src];
`ifdef CLIC_ARB_THRESH_EN
      qual = qual & (ctl_arr[src] > int_thresh);
`endif
      if (qual && (!scan_vld || (ctl_arr[src] > scan_ctl))) begin
        scan_vld = 1'b1;
        scan_id  = src;
        scan_ctl = ctl_arr[src];
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    grp_cnt_d  = grp_cnt_q;
    best_vld_d = best_vld_q;
    best_id_d  = best_id_q;
    best_ctl_d = best_ctl_q;
    sel_d      = sel_q;
    id_d       = id_q;
    ctl_d      = ctl_q;
    vld_d      = vld_q;

    unique case (state_q)
      ST_IDLE: begin
        state_d    = ST_SCAN;
        grp_cnt_d  = '0;
        best_vld_d = 1'b0;
        best_id_d  = '0;
        best_ctl_d = '0;
      end
      ST_SCAN: begin
        best_vld_d = scan_vld;
        best_id_d  = scan_id;
        best_ctl_d = scan_ctl;
        if (grp_cnt_q == LAST_GRP) begin
          state_d   = ST_UPDATE;
          grp_cnt_d = '0;
        end else begin
          grp_cnt_d = grp_cnt_q + 1'b1;
        end
      end
      ST_UPDATE: begin
        // Publish the round result and start the next round in one edge.
        vld_d = best_vld_q;
        sel_d = '0;
        if (best_vld_q) begin
          sel_d[best_id_q] = 1'b1;
          id_d  = best_id_q;
          ctl_d = best_ctl_q;
        end else begin
          id_d  = '0;
          ctl_d = '0;
        end
        state_d    = ST_SCAN;
        grp_cnt_d  = '0;
        best_vld_d = 1'b0;
        best_id_d  = '0;
        best_ctl_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // arb_clear overrides every transition and zeros the outputs.
    if (arb_clear) begin
      state_d    = ST_IDLE;
      grp_cnt_d  = '0;
      best_vld_d = 1'b0;
      best_id_d  = '0;
      best_ctl_d = '0;
      sel_d      = '0;
      id_d       = '0;
      ctl_d      = '0;
      vld_d      = 1'b0;
    end
  end

  always_ff @(posedge clic_clk or posedge clic_rst) begin
    if (clic_rst) begin
      state_q    <= ST_IDLE;
      grp_cnt_q  <= '0;
      best_vld_q <= 1'b0;
      best_id_q  <= '0;
      best_ctl_q <= '0;
      sel_q      <= '0;
      id_q       <= '0;
      ctl_q      <= '0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grp_cnt_q  <= grp_cnt_d;
      best_vld_q <= best_vld_d;
      best_id_q  <= best_id_d;
      best_ctl_q <= best_ctl_d;
      sel_q      <= sel_d;
      id_q       <= id_d;
      ctl_q      <= ctl_d;
      vld_q      <= vld_d;
    end
  end

  assign arb_sel_onehot = sel_q;
  assign arb_id         = id_q;
  assign arb_ctl        = ctl_q;
  assign arb_vld        = vld_q;
  assign arb_busy       = (state_q == ST_SCAN);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_clic_arb.sv
// ---------------------------------------------------------------------------
// tb_clic_arb -- directed bench for clic_arb with the default parameters
// (64 sources, 8 per group, 8-bit ctl, 6-bit ID).
// The inputs are driven 1 ns after each rising edge. The outputs are sampled
// at that same point, before the next edge.
// ---------------------------------------------------------------------------
module tb_clic_arb;

  localparam int INT_NUM   = 64;
  localparam int CTL_WIDTH = 8;
  localparam int GRP_NUM   = 8;
  localparam int ID_WIDTH  = 6;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;

  logic                         clk;
  logic                         rst;
  logic [INT_NUM-1:0]           int_pending;
  logic [INT_NUM-1:0]           int_enable;
  logic [INT_NUM*CTL_WIDTH-1:0] int_ctl;
  logic [CTL_WIDTH-1:0]         int_thresh;
  logic                         arb_clear;
  logic [INT_NUM-1:0]           arb_sel_onehot;
  logic [ID_WIDTH-1:0]          arb_id;
  logic [CTL_WIDTH-1:0]         arb_ctl;
  logic                         arb_vld;
  logic                         arb_busy;
  logic [1:0]                   dbg_state;

  int n_checks;
  int n_fail;

  clic_arb #(
    .INT_NUM   (INT_NUM),
    .CTL_WIDTH (CTL_WIDTH),
    .GRP_NUM   (GRP_NUM),
    .ID_WIDTH  (ID_WIDTH)
  ) dut (
    .clic_clk       (clk),
    .clic_rst       (rst),
    .int_pending    (int_pending),
    .int_enable     (int_enable),
    .int_ctl        (int_ctl),
`ifdef CLIC_ARB_THRESH_EN
    .int_thresh     (int_thresh),
`endif
    .arb_clear      (arb_clear),
    .arb_sel_onehot (arb_sel_onehot),
    .arb_id         (arb_id),
    .arb_ctl        (arb_ctl),
    .arb_vld        (arb_vld),
    .arb_busy       (arb_busy),
    .dbg_state_o    (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic vld, input int id, input logic [7:0] ctl);
    logic [63:0] exp_sel;
    exp_sel = '0;
    if (vld) exp_sel[id] = 1'b1;
    check_eq({tag, ".vld"}, 64'(arb_vld), 64'(vld));
    check_eq({tag, ".id"},  64'(arb_id),  vld ? 64'(id)  : 64'd0);
    check_eq({tag, ".ctl"}, 64'(arb_ctl), vld ? 64'(ctl) : 64'd0);
    check_eq({tag, ".sel"}, arb_sel_onehot, exp_sel);
    check_eq({tag, ".onehot0"}, 64'($onehot0(arb_sel_onehot)), 64'd1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    int_pending = '0;
    int_enable  = '0;
    int_ctl     = '0;
  endtask

  task automatic set_src(input int idx, input logic [7:0] ctl);
    int_pending[idx] = 1'b1;
    int_enable[idx]  = 1'b1;
    int_ctl[idx*CTL_WIDTH +: CTL_WIDTH] = ctl;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    arb_clear  = 1'b0;
    int_thresh = 8'h00;
    clear_inputs();
    tick(2);

    // reset state
    check_out("reset", 1'b0, 0, 8'h00);
    check_eq("reset.state", 64'(dbg_state), 64'(S_IDLE));
    check_eq("reset.busy", 64'(arb_busy), 64'd0);

    // single source, first result 10 cycles after release
    set_src(5, 8'h40);
    rst = 1'b0;
    tick(1);
    check_eq("rel1.state", 64'(dbg_state), 64'(S_SCAN));
    check_eq("rel1.busy", 64'(arb_busy), 64'd1);
    tick(8);
    check_eq("rel9.state", 64'(dbg_state), 64'(S_UPDATE));
    check_eq("rel9.busy", 64'(arb_busy), 64'd0);
    check_eq("rel9.vld", 64'(arb_vld), 64'd0);
    tick(1);
    check_out("src5", 1'b1, 5, 8'h40);
    check_eq("rel10.state", 64'(dbg_state), 64'(S_SCAN));

    // equal ctl across groups: the lower index wins; outputs hold during the round
    clear_inputs();
    set_src(3, 8'h80); set_src(60, 8'h80); set_src(20, 8'h7F);
    tick(8);
    check_out("hold", 1'b1, 5, 8'h40);
    tick(1);
    check_out("tie3_60", 1'b1, 3, 8'h80);

    // equal ctl inside one group and across groups
    clear_inputs();
    set_src(17, 8'h90); set_src(16, 8'h90); set_src(40, 8'h90);
    tick(9);
    check_out("tie16", 1'b1, 16, 8'h90);

    // top index; a pending but disabled source is ignored
    clear_inputs();
    set_src(63, 8'hFF);
    int_pending[62] = 1'b1;
    int_ctl[62*CTL_WIDTH +: CTL_WIDTH] = 8'hFF;
    tick(9);
    check_out("src63", 1'b1, 63, 8'hFF);

    // source 0 with ctl 0 (with the threshold macro, 0 > 0 fails)
    clear_inputs();
    set_src(0, 8'h00);
    tick(9);
`ifdef CLIC_ARB_THRESH_EN
    check_out("src0", 1'b0, 0, 8'h00);
`else
    check_out("src0", 1'b1, 0, 8'h00);
`endif

    // pending without enable -> no winner
    clear_inputs();
    int_pending[9] = 1'b1;
    int_ctl[9*CTL_WIDTH +: CTL_WIDTH] = 8'hAA;
    tick(9);
    check_out("noen9", 1'b0, 0, 8'h00);

    // a change in an already scanned group waits for the next round
    clear_inputs();
    set_src(5, 8'h40);
    tick(3);
    set_src(2, 8'hF0);
    tick(6);
    check_out("late_r1", 1'b1, 5, 8'h40);
    tick(9);
    check_out("late_r2", 1'b1, 2, 8'hF0);

    // arb_clear at grp_cnt=4
    tick(4);
    arb_clear = 1'b1;
    tick(1);
    arb_clear = 1'b0;
    check_out("clear", 1'b0, 0, 8'h00);
    check_eq("clear.state", 64'(dbg_state), 64'(S_IDLE));
    tick(9);
    check_eq("clear9.vld", 64'(arb_vld), 64'd0);
    check_eq("clear9.state", 64'(dbg_state), 64'(S_UPDATE));
    tick(1);
    check_out("clear10", 1'b1, 2, 8'hF0);

    // asynchronous reset at grp_cnt=6
    tick(6);
    check_eq("prerst.state", 64'(dbg_state), 64'(S_SCAN));
    rst = 1'b1;
    #1;
    check_out("async_rst", 1'b0, 0, 8'h00);
    check_eq("async_rst.state", 64'(dbg_state), 64'(S_IDLE));
    check_eq("async_rst.busy", 64'(arb_busy), 64'd0);
    tick(1);
    rst = 1'b0;
    tick(9);
    check_eq("rst9.vld", 64'(arb_vld), 64'd0);
    tick(1);
    check_out("rst10", 1'b1, 2, 8'hF0);

`ifdef CLIC_ARB_THRESH_EN
    // threshold: a source must be strictly above int_thresh
    clear_inputs();
    int_thresh = 8'h40;
    set_src(7, 8'h40); set_src(8, 8'h41);
    tick(9);
    check_out("thr8", 1'b1, 8, 8'h41);
    int_pending[8] = 1'b0;
    int_enable[8]  = 1'b0;
    tick(9);
    check_out("thr_none", 1'b0, 0, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
